// File: rtl/adc_ctrl_pkg.sv
// Shared state encoding, sample width and parameter defaults for adc_fifo_read_ctrl.
package adc_ctrl_pkg;

    localparam int ADC_W            = 12;
    localparam int DEF_READ_LATENCY = 1;
    localparam int DEF_AVG_LOG2     = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/adc_fifo_read_ctrl.sv
// Pops ADC samples from a FIFO and emits (with ADC_AVG_EN) the truncated mean of 2^AVG_LOG2 samples.
// Latency: pop strobe one cycle after non-empty seen; capture READ_LATENCY cycles after the pop.
// Backpressure: no pops while a result waits in OUT for sample_ready.
module adc_fifo_read_ctrl
    import adc_ctrl_pkg::*;
#(
    parameter int READ_LATENCY = DEF_READ_LATENCY,
    parameter int AVG_LOG2     = DEF_AVG_LOG2
) (
    input  logic             clk_consumer,
    input  logic             rst_n,
    input  logic [ADC_W-1:0] fifo_data,
    input  logic             fifo_empty,
    output logic             fifo_read_en,
    output logic [ADC_W-1:0] sample_data,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             busy
);

    if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
        $error("adc_fifo_read_ctrl: READ_LATENCY must be 1 or 2");
    end
    if (AVG_LOG2 < 0 || AVG_LOG2 > 4) begin : g_bad_avg
        $error("adc_fifo_read_ctrl: AVG_LOG2 must be 0..4");
    end

    state_t           state_q, state_d;
    logic             rd_en_q, rd_en_d;
    logic [1:0]       lat_cnt_q, lat_cnt_d;
    logic [ADC_W-1:0] sample_data_q, sample_data_d;
    logic             sample_valid_q, sample_valid_d;

`ifdef ADC_AVG_EN
    localparam int               ACC_W = ADC_W + AVG_LOG2;
    localparam int               CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] BATCH = CNT_W'(1 << AVG_LOG2);

    // Sized so 2^AVG_LOG2 full-scale samples can never wrap.
    logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
`endif

    always_comb begin
        state_d        = state_q;
        rd_en_d        = 1'b0;
        lat_cnt_d      = lat_cnt_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
`ifdef ADC_AVG_EN
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        acc_sum = acc_q + ACC_W'(fifo_data);
        cnt_inc = cnt_q + CNT_W'(1);
`endif
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_en_d   = 1'b1;
                    lat_cnt_d = 2'(READ_LATENCY);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // Counter reaches zero in the cycle the FIFO data is valid.
                if (lat_cnt_q != 2'd0) begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end else begin
`ifdef ADC_AVG_EN
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (cnt_inc == BATCH) begin
                        sample_data_d  = acc_sum[ACC_W-1 -: ADC_W];
                        sample_valid_d = 1'b1;
                        state_d        = OUT;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    sample_data_d  = fifo_data;
                    sample_valid_d = 1'b1;
                    state_d        = OUT;
`endif
                end
            end
            OUT: begin
                if (sample_ready) begin
                    sample_valid_d = 1'b0;
                    state_d        = IDLE;
`ifdef ADC_AVG_EN
                    acc_d = '0;
                    cnt_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_consumer or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rd_en_q        <= 1'b0;
            lat_cnt_q      <= 2'd0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
`ifdef ADC_AVG_EN
            acc_q <= '0;
            cnt_q <= '0;
`endif
        end else begin
            state_q        <= state_d;
            rd_en_q        <= rd_en_d;
            lat_cnt_q      <= lat_cnt_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
`ifdef ADC_AVG_EN
            acc_q <= acc_d;
            cnt_q <= cnt_d;
`endif
        end
    end

    assign fifo_read_en = rd_en_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_adc_fifo_read_ctrl.sv
// Randomized bench for adc_fifo_read_ctrl against a FIFO-plus-batch-mean reference model.
`timescale 1ns/1ps
module tb_adc_fifo_read_ctrl;

    localparam int RL = 2;
    localparam int AL = 3;
`ifdef ADC_AVG_EN
    localparam int N = 1 << AL;
`else
    localparam int N = 1;
`endif

    logic        clk_consumer = 1'b0;
    logic        rst_n;
    logic [11:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_read_en;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;

    always #5 clk_consumer = ~clk_consumer;

    adc_fifo_read_ctrl #(.READ_LATENCY(RL), .AVG_LOG2(AL)) dut (
        .clk_consumer (clk_consumer),
        .rst_n        (rst_n),
        .fifo_data    (fifo_data),
        .fifo_empty   (fifo_empty),
        .fifo_read_en (fifo_read_en),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy)
    );

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          pops = 0;
    int          outs = 0;
    int          last_pop_cyc = 0;
    logic [11:0] last_out = '0;
    logic        gap = 1'b0;

    logic [11:0] fifo_q[$];
    logic [11:0] exp_q[$];
    logic        pend_v[3];
    logic [11:0] pend_d[3];
    int          bsum = 0;
    int          bcnt = 0;

    task automatic clear_model();
        fifo_q.delete();
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            pend_v[i] = 1'b0;
            pend_d[i] = '0;
        end
        bsum = 0;
        bcnt = 0;
    endtask

    task automatic push(input logic [11:0] v);
        fifo_q.push_back(v);
    endtask

    // One clock: FIFO model with RL-cycle read latency, batch-mean model, output monitor.
    task automatic tick();
        logic        hs;
        logic        hold;
        logic [11:0] snap;
        logic [11:0] exp;
        fifo_empty = gap || (fifo_q.size() == 0);
        hs   = sample_valid && sample_ready;
        hold = sample_valid && !sample_ready;
        snap = sample_data;
        @(negedge clk_consumer);
        cyc++;
        if (!rst_n) return;
        if (fifo_read_en) begin
            pops++;
            last_pop_cyc = cyc;
            tests++;
            if (fifo_empty !== 1'b0 || fifo_q.size() == 0) begin
                fails++;
                $display("FAIL pop_while_empty: fifo_read_en=1 with fifo_empty=%0b queued=%0d", fifo_empty, fifo_q.size());
            end
        end
        for (int i = 2; i > 0; i--) begin
            pend_v[i] = pend_v[i-1];
            pend_d[i] = pend_d[i-1];
        end
        pend_v[0] = 1'b0;
        pend_d[0] = '0;
        if (fifo_read_en && fifo_q.size() > 0) begin
            pend_v[0] = 1'b1;
            pend_d[0] = fifo_q.pop_front();
        end
        if (pend_v[RL]) begin
            fifo_data = pend_d[RL];
            bsum += int'(pend_d[RL]);
            bcnt++;
            if (bcnt == N) begin
                exp_q.push_back(12'(bsum / N));
                bsum = 0;
                bcnt = 0;
            end
        end else begin
            fifo_data = 12'($urandom);
        end
        if (hold) begin
            tests++;
            if (sample_valid !== 1'b1 || sample_data !== snap) begin
                fails++;
                $display("FAIL stall_hold: valid=%0b data=%03h, required valid=1 data=%03h", sample_valid, sample_data, snap);
            end
        end
        if (hs) begin
            tests++;
            outs++;
            last_out = snap;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: data=%03h with no result due", snap);
            end else begin
                exp = exp_q.pop_front();
                if (snap !== exp) begin
                    fails++;
                    $display("FAIL sample_data: got %03h expected %03h", snap, exp);
                end
            end
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        sample_ready = 1'b1;
        gap = 1'b0;
        while ((fifo_q.size() != 0 || pend_v[0] || pend_v[1] || pend_v[2] ||
                exp_q.size() != 0 || sample_valid) && n < 3000) begin
            tick();
            n++;
        end
        tests++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_timeout: still pending %0d results after %0d cycles, required 0", tag, exp_q.size(), n);
        end
    endtask

    task automatic wait_pops(input int target, input string tag);
        int n = 0;
        while (pops < target && n < 500) begin
            tick();
            n++;
        end
        tests++;
        if (pops < target) begin
            fails++;
            $display("FAIL %s_pops_timeout: pops=%0d required %0d", tag, pops, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        gap = 1'b0;
        sample_ready = 1'b1;
        fifo_data = '0;
        fifo_empty = 1'b1;
        clear_model();
        #2;
        tests++;
        if ({fifo_read_en, sample_valid, busy} !== 3'b000 || sample_data !== 12'h000) begin
            fails++;
            $display("FAIL reset_outputs: rd=%0b valid=%0b busy=%0b data=%03h, required all 0",
                     fifo_read_en, sample_valid, busy, sample_data);
        end
        repeat (3) tick();
        rst_n = 1'b1;
        pops = 0;
        repeat (4) tick();
        tests++;
        if (pops !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_empty: pops=%0d busy=%0b, required 0 and 0", pops, busy);
        end
    endtask

    task automatic test_ramp();
        int          p0 = pops;
        logic [11:0] want;
`ifdef ADC_AVG_EN
        want = 12'h103;
`else
        want = 12'h107;
`endif
        for (int i = 0; i < 8; i++) push(12'h100 + 12'(i));
        drain("ramp");
        tests++;
        if (pops - p0 !== 8) begin
            fails++;
            $display("FAIL ramp_pops: got %0d pulses, required 8", pops - p0);
        end
        tests++;
        if (last_out !== want) begin
            fails++;
            $display("FAIL ramp_result: got %03h, required %03h", last_out, want);
        end
    endtask

    task automatic test_extremes();
        int o0 = outs;
        for (int i = 0; i < 8; i++) push(12'hFFF);
        drain("full_scale");
        tests++;
        if (last_out !== 12'hFFF) begin
            fails++;
            $display("FAIL full_scale: got %03h, required fff", last_out);
        end
        for (int i = 0; i < 8; i++) push(12'h000);
        drain("zero");
        tests++;
        if (last_out !== 12'h000 || outs - o0 !== 16 / N) begin
            fails++;
            $display("FAIL zero_scale: got %03h outputs=%0d, required 000 outputs=%0d", last_out, outs - o0, 16 / N);
        end
    endtask

    task automatic test_backpressure();
        int          n = 0;
        int          p0;
        logic [11:0] d0;
        sample_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) push(12'($urandom));
        while (!sample_valid && n < 500) begin
            tick();
            n++;
        end
        tests++;
        if (!sample_valid) begin
            fails++;
            $display("FAIL bp_valid_timeout: sample_valid=0, required 1");
        end
        p0 = pops;
        d0 = sample_data;
        repeat (5) tick();
        tests++;
        if (pops !== p0 || sample_valid !== 1'b1 || sample_data !== d0) begin
            fails++;
            $display("FAIL bp_stall: pops=%0d valid=%0b data=%03h, required pops=%0d valid=1 data=%03h",
                     pops - p0, sample_valid, sample_data, 0, d0);
        end
        sample_ready = 1'b1;
        tick();
        tests++;
        if (sample_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: valid=%0b busy=%0b, required 0 and 0", sample_valid, busy);
        end
        drain("backpressure");
    endtask

    task automatic test_gap();
        int p0;
        int o0 = outs;
        for (int i = 0; i < 3; i++) push(12'($urandom));
        wait_pops(pops + 3, "gap_head");
        gap = 1'b1;
        p0 = pops;
        for (int i = 0; i < 5; i++) push(12'($urandom));
        repeat (10) tick();
        tests++;
        if (pops !== p0) begin
            fails++;
            $display("FAIL gap_pops: got %0d pops during empty gap, required 0", pops - p0);
        end
        drain("gap");
        tests++;
        if (outs - o0 !== 8 / N) begin
            fails++;
            $display("FAIL gap_outputs: got %0d outputs, required %0d", outs - o0, 8 / N);
        end
    endtask

    task automatic test_reset_mid();
        int o0;
        for (int i = 0; i < 3; i++) push(12'h800);
        wait_pops(pops + 3, "rst_head");
        tick();
        rst_n = 1'b0;
        clear_model();
        #1;
        tests++;
        if ({fifo_read_en, sample_valid, busy} !== 3'b000 || sample_data !== 12'h000) begin
            fails++;
            $display("FAIL async_reset: rd=%0b valid=%0b busy=%0b data=%03h, required all 0",
                     fifo_read_en, sample_valid, busy, sample_data);
        end
        repeat (3) tick();
        tests++;
        if ({fifo_read_en, sample_valid, busy} !== 3'b000 || sample_data !== 12'h000) begin
            fails++;
            $display("FAIL held_reset: rd=%0b valid=%0b busy=%0b data=%03h, required all 0",
                     fifo_read_en, sample_valid, busy, sample_data);
        end
        rst_n = 1'b1;
        o0 = outs;
        for (int i = 0; i < 8; i++) push(12'h010);
        drain("post_reset");
        tests++;
        if (last_out !== 12'h010 || outs - o0 !== 8 / N) begin
            fails++;
            $display("FAIL post_reset: got %03h outputs=%0d, required 010 outputs=%0d", last_out, outs - o0, 8 / N);
        end
    endtask

    task automatic test_single_latency();
        int n = 0;
        for (int i = 0; i < N; i++) push(12'hABC);
        while (!sample_valid && n < 500) begin
            tick();
            n++;
        end
        tests++;
        if (cyc - last_pop_cyc !== RL + 1 || sample_data !== 12'hABC) begin
            fails++;
            $display("FAIL single_latency: valid %0d cycles after pop data=%03h, required %0d cycles data=abc",
                     cyc - last_pop_cyc, sample_data, RL + 1);
        end
        drain("single");
    endtask

    task automatic test_random();
        int o0 = outs;
        for (int i = 0; i < 32; i++) push(12'($urandom));
        repeat (400) begin
            sample_ready = ($urandom_range(0, 3) != 0);
            gap = ($urandom_range(0, 7) == 0);
            tick();
        end
        drain("random");
        tests++;
        if (outs - o0 !== 32 / N) begin
            fails++;
            $display("FAIL random_outputs: got %0d outputs, required %0d", outs - o0, 32 / N);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_extremes();
        test_backpressure();
        test_gap();
        test_reset_mid();
        test_single_latency();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
